// File: rtl/nand_chk_pkg.sv
// Shared types and limits for the NAND gate sweep checker.
// Holds the sweep FSM state encoding and a saturating counter helper.
package nand_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int N_IN_MAX   = 5;
   localparam int SETTLE_MAX = 15;

   localparam logic [5:0] ERR_MAX = 6'd63;

   // The error counter holds at its ceiling instead of wrapping to zero.
   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      logic [5:0] r;
      if (v == ERR_MAX) begin
         r = v;
      end else begin
         r = v + 6'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nand_sweep_checker_golden.sv
// Golden reference NAND: low only when every input bit is high.
module nand_golden #(
   parameter int N_IN = 5
) (
   input  logic [N_IN-1:0] i_vec,
   output logic            o_golden
);

   assign o_golden = ~(&i_vec);

endmodule

// File: rtl/nand_sweep_checker.sv
// Exhaustive sweep of all N_IN-bit vectors into two NAND implementations,
// comparing each against the golden NAND and accumulating failure statistics.
module nand_sweep_checker
   import nand_chk_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] vec,
   input  logic            o_e,
   input  logic            o_c,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [5:0]      err_count,
   output logic [N_IN-1:0] first_fail,
   output logic            mismatch_e,
   output logic            mismatch_c
);

   localparam int              SETTLE_EFF  = (SETTLE > SETTLE_MAX) ? SETTLE_MAX :
                                             (SETTLE < 1) ? 1 : SETTLE;
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_EFF - 1);
   localparam logic [N_IN-1:0] VEC_ZERO    = {N_IN{1'b0}};
   localparam logic [N_IN-1:0] VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};

   state_t          r_state;
   logic [3:0]      r_settle_cnt;
   logic [N_IN-1:0] r_vec;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [5:0]      r_err_count;
   logic [N_IN-1:0] r_first_fail;
   logic            r_mismatch_e;
   logic            r_mismatch_c;

   logic            w_golden;
   logic            w_fail_e;
   logic            w_fail_c;

   nand_golden #(
      .N_IN (N_IN)
   ) u_golden (
      .i_vec    (r_vec),
      .o_golden (w_golden)
   );

   assign w_fail_e = (o_e != w_golden);
   assign w_fail_c = (o_c != w_golden);

   // Sweep sequencer: settle, check, advance; results held until next start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 4'd0;
         r_vec        <= VEC_ZERO;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= 6'd0;
         r_first_fail <= VEC_ZERO;
         r_mismatch_e <= 1'b0;
         r_mismatch_c <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_vec        <= VEC_ZERO;
                  r_settle_cnt <= 4'd0;
                  r_err_count  <= 6'd0;
                  r_first_fail <= VEC_ZERO;
                  r_mismatch_e <= 1'b0;
                  r_mismatch_c <= 1'b0;
                  r_pass       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            ST_CHECK: begin
               if (w_fail_e || w_fail_c) begin
                  r_err_count <= sat_inc(r_err_count);
                  // A zero count means this is the sweep's first failing vector.
                  if (r_err_count == 6'd0) begin
                     r_first_fail <= r_vec;
                  end
               end
               if (w_fail_e) begin
                  r_mismatch_e <= 1'b1;
               end
               if (w_fail_c) begin
                  r_mismatch_c <= 1'b1;
               end
               if (&r_vec) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_vec        <= r_vec + VEC_ONE;
                  r_settle_cnt <= 4'd0;
                  r_state      <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_pass  <= (r_err_count == 6'd0);
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign vec        = r_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err_count;
   assign first_fail = r_first_fail;
   assign mismatch_e = r_mismatch_e;
   assign mismatch_c = r_mismatch_c;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Bench for nand_sweep_checker: three configurations swept side by side with
// per-vector fault masks on each gate, checked against a counting reference.
module tb_nand_sweep_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   // Per configuration, bit v of a mask flips that gate's output at vector v.
   logic [31:0] fe [3];
   logic [31:0] fc [3];

   logic [1:0] v2;  logic [2:0] v3;  logic [4:0] v5;
   logic [1:0] ff2; logic [2:0] ff3; logic [4:0] ff5;
   logic oe2, oc2, oe3, oc3, oe5, oc5;
   logic busy2, busy3, busy5, done2, done3, done5, pass2, pass3, pass5;
   logic me2, me3, me5, mc2, mc3, mc5;
   logic [5:0] err2, err3, err5;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign oe2 = ((v2 == 2'b11) ? 1'b0 : 1'b1) ^ fe[0][v2];
   assign oc2 = ((v2 == 2'b11) ? 1'b0 : 1'b1) ^ fc[0][v2];
   assign oe3 = ((v3 == 3'b111) ? 1'b0 : 1'b1) ^ fe[1][v3];
   assign oc3 = ((v3 == 3'b111) ? 1'b0 : 1'b1) ^ fc[1][v3];
   assign oe5 = ((v5 == 5'b11111) ? 1'b0 : 1'b1) ^ fe[2][v5];
   assign oc5 = ((v5 == 5'b11111) ? 1'b0 : 1'b1) ^ fc[2][v5];

   nand_sweep_checker #(.N_IN(2), .SETTLE(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .vec(v2), .o_e(oe2), .o_c(oc2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail(ff2), .mismatch_e(me2), .mismatch_c(mc2));

   nand_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut3 (
      .clk(clk), .rst(rst), .start(start), .vec(v3), .o_e(oe3), .o_c(oc3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_fail(ff3), .mismatch_e(me3), .mismatch_c(mc3));

   nand_sweep_checker #(.N_IN(5), .SETTLE(2)) u_dut5 (
      .clk(clk), .rst(rst), .start(start), .vec(v5), .o_e(oe5), .o_c(oc5),
      .busy(busy5), .done(done5), .pass(pass5), .err_count(err5),
      .first_fail(ff5), .mismatch_e(me5), .mismatch_c(mc5));

   logic [31:0] vec_a [3];
   logic [31:0] ff_a  [3];
   logic [31:0] err_a [3];
   logic busy_a [3];
   logic done_a [3];
   logic pass_a [3];
   logic me_a   [3];
   logic mc_a   [3];

   assign vec_a[0] = 32'(v2);   assign vec_a[1] = 32'(v3);   assign vec_a[2] = 32'(v5);
   assign ff_a[0]  = 32'(ff2);  assign ff_a[1]  = 32'(ff3);  assign ff_a[2]  = 32'(ff5);
   assign err_a[0] = 32'(err2); assign err_a[1] = 32'(err3); assign err_a[2] = 32'(err5);
   assign busy_a[0] = busy2; assign busy_a[1] = busy3; assign busy_a[2] = busy5;
   assign done_a[0] = done2; assign done_a[1] = done3; assign done_a[2] = done5;
   assign pass_a[0] = pass2; assign pass_a[1] = pass3; assign pass_a[2] = pass5;
   assign me_a[0]   = me2;   assign me_a[1]   = me3;   assign me_a[2]   = me5;
   assign mc_a[0]   = mc2;   assign mc_a[1]   = mc3;   assign mc_a[2]   = mc5;

   function automatic int nin(input int k);
      return (k == 0) ? 2 : (k == 1) ? 3 : 5;
   endfunction

   function automatic int settle(input int k);
      return (k == 2) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_d%0d_vec", tag, k), vec_a[k], 32'd0);
         chk($sformatf("%s_d%0d_busy", tag, k), 32'(busy_a[k]), 32'd0);
         chk($sformatf("%s_d%0d_done", tag, k), 32'(done_a[k]), 32'd0);
         chk($sformatf("%s_d%0d_pass", tag, k), 32'(pass_a[k]), 32'd0);
         chk($sformatf("%s_d%0d_err", tag, k), err_a[k], 32'd0);
         chk($sformatf("%s_d%0d_ff", tag, k), ff_a[k], 32'd0);
         chk($sformatf("%s_d%0d_me", tag, k), 32'(me_a[k]), 32'd0);
         chk($sformatf("%s_d%0d_mc", tag, k), 32'(mc_a[k]), 32'd0);
      end
   endtask

   // One full sweep on all three DUTs; optionally re-pulse start mid-sweep.
   task automatic run_sweep(input string tag, input bit mid_start);
      int exp_err [3]; int exp_ff [3]; int exp_me [3]; int exp_mc [3];
      int done_cyc [3]; int done_cnt [3];
      for (int k = 0; k < 3; k++) begin
         bit found = 1'b0;
         exp_err[k] = 0; exp_ff[k] = 0; exp_me[k] = 0; exp_mc[k] = 0;
         for (int v = 0; v < (1 << nin(k)); v++) begin
            if (fe[k][v] || fc[k][v]) begin
               if (!found) exp_ff[k] = v;
               found = 1'b1;
               exp_err[k]++;
            end
            if (fe[k][v]) exp_me[k] = 1;
            if (fc[k][v]) exp_mc[k] = 1;
         end
         done_cyc[k] = -1;
         done_cnt[k] = 0;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 110; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            if (done_a[k]) begin
               if (done_cnt[k] == 0) done_cyc[k] = cyc;
               done_cnt[k]++;
            end
            if (cyc == 0) chk($sformatf("%s_d%0d_busy0", tag, k), 32'(busy_a[k]), 32'd1);
         end
         if (mid_start && cyc == 7) begin
            chk($sformatf("%s_midvec", tag), vec_a[2], 32'd2);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_d%0d_donecyc", tag, k), 32'(done_cyc[k]),
             32'(((1 << nin(k)) * (settle(k) + 1)) + 1));
         chk($sformatf("%s_d%0d_donecnt", tag, k), 32'(done_cnt[k]), 32'd1);
         chk($sformatf("%s_d%0d_err", tag, k), err_a[k], 32'(exp_err[k]));
         chk($sformatf("%s_d%0d_ff", tag, k), ff_a[k], 32'(exp_ff[k]));
         chk($sformatf("%s_d%0d_me", tag, k), 32'(me_a[k]), 32'(exp_me[k]));
         chk($sformatf("%s_d%0d_mc", tag, k), 32'(mc_a[k]), 32'(exp_mc[k]));
         chk($sformatf("%s_d%0d_pass", tag, k), 32'(pass_a[k]), 32'(exp_err[k] == 0));
         chk($sformatf("%s_d%0d_vec", tag, k), vec_a[k], 32'((1 << nin(k)) - 1));
         chk($sformatf("%s_d%0d_busy", tag, k), 32'(busy_a[k]), 32'd0);
      end
   endtask

   initial begin
      int n_done;
      fe = '{32'd0, 32'd0, 32'd0};
      fc = '{32'd0, 32'd0, 32'd0};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Good 2-input gates, 3-input o_c stuck at 0, 5-input o_e inverted.
      fe = '{32'd0, 32'd0, 32'hFFFF_FFFF};
      fc = '{32'd0, 32'h0000_007F, 32'd0};
      run_sweep("dir", 1'b1);
      chk("dir_n2_err", err_a[0], 32'd0);
      chk("dir_n2_pass", 32'(pass_a[0]), 32'd1);
      chk("dir_n3_err", err_a[1], 32'd7);
      chk("dir_n3_ff", ff_a[1], 32'd0);
      chk("dir_n3_mc", 32'(mc_a[1]), 32'd1);
      chk("dir_n3_me", 32'(me_a[1]), 32'd0);
      chk("dir_n3_pass", 32'(pass_a[1]), 32'd0);
      chk("dir_n5_err", err_a[2], 32'd32);
      chk("dir_n5_me", 32'(me_a[2]), 32'd1);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) begin
            fe[k] = (r == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
            fc[k] = (r == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
         end
         run_sweep($sformatf("rnd%0d", r), 1'b0);
         repeat (3) @(negedge clk);
      end

      // Abort a faulty sweep with reset once the 2-input DUT reaches vector 3.
      for (int k = 0; k < 3; k++) begin
         fe[k] = 32'h0000_0001 | $urandom;
         fc[k] = 32'h0000_0002 | $urandom;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_vec", vec_a[0], 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("abort");
      n_done = 0;
      for (int c = 0; c < 30; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (done_a[k] || busy_a[k]) n_done++;
         end
         @(negedge clk);
      end
      chk("abort_quiet", 32'(n_done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         fe[k] = $urandom & $urandom;
         fc[k] = $urandom & $urandom;
      end
      run_sweep("fresh", 1'b0);

      // Reset and start together: reset wins and the FSM stays idle.
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rs_d%0d_busy", k), 32'(busy_a[k]), 32'd0);
         chk($sformatf("rs_d%0d_vec", k), vec_a[k], 32'd0);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rs_d%0d_busy2", k), 32'(busy_a[k]), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
